// File: rtl/eth_crc_pkg.sv
// Shared constants and state type for the Ethernet FCS inserter.
package eth_crc_pkg;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Good-frame residue in MSB-first bit order; the reflected CRC register
    // holds its bit reversal (0xDEBB20E3) after a frame plus its FCS.
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    typedef enum logic [1:0] {
        PASS,
        PAD,
        FCS
    } fcs_state_t;

endpackage

// File: rtl/crc32_byte_update.sv
// One-byte update of the reflected CRC-32 register (8 unrolled shift/xor steps).
module crc32_byte_update (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    import eth_crc_pkg::*;

    logic [31:0] c;

    // Fold the byte into the low bits, then shift out one bit per step.
    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_fcs_inserter.sv
// Byte-stream frame re-emitter: pads short frames with zeros, then appends
// the 4-byte Ethernet FCS (complemented CRC, LSB first).
module eth_fcs_inserter #(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 32,
    parameter int MIN_FRAME  = 60,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  frame_done
);
    import eth_crc_pkg::*;

    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_FRAME);

    fcs_state_t           state;
    logic [CRC_WIDTH-1:0] crc;
    logic [CNT_WIDTH-1:0] byte_cnt;
    logic [1:0]           fcs_idx;

    logic                 out_free;
    logic                 in_xfer;
    logic                 last_xfer;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [7:0]           crc_byte;
    logic [7:0]           fcs_byte;
    logic [31:0]          crc_next;
    logic [31:0]          fcs_word;

    assign out_free  = !m_valid || m_ready;
    assign s_ready   = rst && (state == PASS) && out_free;
    assign in_xfer   = s_valid && s_ready;
    assign last_xfer = m_valid && m_ready && m_last;
    assign cnt_inc   = (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
    assign crc_byte  = (state == PASS) ? s_data : 8'h00;
    assign fcs_word  = ~crc;

    // Pick the FCS byte for the current index, least significant byte first.
    always_comb begin
        fcs_byte = fcs_word[7:0];
        case (fcs_idx)
            2'd0: fcs_byte = fcs_word[7:0];
            2'd1: fcs_byte = fcs_word[15:8];
            2'd2: fcs_byte = fcs_word[23:16];
            2'd3: fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    crc32_byte_update u_crc (
        .crc_in  (crc),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    // Frame FSM: payload pass-through, zero padding, FCS emission; the output
    // register is only reloaded when empty or being drained this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PASS;
            crc        <= CRC_INIT;
            byte_cnt   <= '0;
            fcs_idx    <= 2'd0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                PASS: begin
                    if (in_xfer) begin
                        m_valid  <= 1'b1;
                        m_data   <= s_data;
                        m_last   <= 1'b0;
                        crc      <= crc_next;
                        byte_cnt <= cnt_inc;
                        if (s_last) begin
                            if (cnt_inc < MIN_CNT) begin
                                state <= PAD;
                            end else begin
                                state   <= FCS;
                                fcs_idx <= 2'd0;
                            end
                        end
                    end
                end
                PAD: begin
                    if (out_free) begin
                        m_valid  <= 1'b1;
                        m_data   <= '0;
                        m_last   <= 1'b0;
                        crc      <= crc_next;
                        byte_cnt <= cnt_inc;
                        if (cnt_inc >= MIN_CNT) begin
                            state   <= FCS;
                            fcs_idx <= 2'd0;
                        end
                    end
                end
                FCS: begin
                    if (last_xfer) begin
                        frame_done <= 1'b1;
                        m_last     <= 1'b0;
                        crc        <= CRC_INIT;
                        byte_cnt   <= '0;
                        fcs_idx    <= 2'd0;
                        state      <= PASS;
                    end else if (out_free) begin
                        m_valid <= 1'b1;
                        m_data  <= fcs_byte;
                        m_last  <= (fcs_idx == 2'd3);
                        fcs_idx <= fcs_idx + 2'd1;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Scoreboard bench for eth_fcs_inserter: one instance without padding, one
// padding to 60 bytes; 'sel' chooses which instance the tasks observe.
module tb_eth_fcs_inserter;
    import eth_crc_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_last, m_ready;
    logic [7:0] s_data;
    logic       sel;

    logic       s_ready0, m_valid0, m_last0, frame_done0;
    logic [7:0] m_data0;
    logic       s_ready1, m_valid1, m_last1, frame_done1;
    logic [7:0] m_data1;

    logic       s_ready_s, m_valid_s, m_last_s, frame_done_s;
    logic [7:0] m_data_s;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    done_cnt, stall_viol, sready_viol;
    bit    tail, drv_timeout;

    always #5 clk = ~clk;

    eth_fcs_inserter #(.MIN_FRAME(0)) dut_min0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid0), .m_ready(m_ready),
        .m_data(m_data0), .m_last(m_last0), .frame_done(frame_done0)
    );

    eth_fcs_inserter #(.MIN_FRAME(60)) dut_min60 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready),
        .m_data(m_data1), .m_last(m_last1), .frame_done(frame_done1)
    );

    assign s_ready_s    = sel ? s_ready1    : s_ready0;
    assign m_valid_s    = sel ? m_valid1    : m_valid0;
    assign m_data_s     = sel ? m_data1     : m_data0;
    assign m_last_s     = sel ? m_last1     : m_last0;
    assign frame_done_s = sel ? frame_done1 : frame_done0;

    // Bit-serial reflected CRC-32 reference (data bit LSB first).
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic do_reset();
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1;
        rst = 1'b0; tail = 1'b0; drv_timeout = 1'b0;
        exp_q.delete(); obs_q.delete();
        done_cnt = 0; stall_viol = 0; sready_viol = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one frame and pushes its expected output (payload, pad, FCS).
    task automatic drive_frame(input bq_t data);
        logic [31:0] c;
        int          mn, cnt, waitc;
        bit          acc;
        c = 32'hFFFFFFFF; mn = sel ? 60 : 0; cnt = 0;
        for (int i = 0; i < data.size(); i++) begin
            s_valid = 1'b1; s_data = data[i]; s_last = (i == data.size() - 1);
            acc = 1'b0; waitc = 0;
            while (!acc && waitc < 2000) begin
                @(negedge clk);
                acc = s_ready_s;
                @(posedge clk); #1;
                waitc++;
            end
            if (!acc) begin
                drv_timeout = 1'b1;
                break;
            end
            exp_q.push_back('{d: data[i], l: 1'b0});
            c = crc_step(c, data[i]);
            cnt++;
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        if (!drv_timeout) begin
            tail = 1'b1;
            while (cnt < mn) begin
                exp_q.push_back('{d: 8'h00, l: 1'b0});
                c = crc_step(c, 8'h00);
                cnt++;
            end
            c = ~c;
            for (int k = 0; k < 4; k++) exp_q.push_back('{d: c[8*k +: 8], l: (k == 3)});
        end
    endtask

    // Collects n output transfers, watching stalls, s_ready and frame_done.
    task automatic collect(input int n, input bit rnd, input int budget, output bit timed_out);
        int         cycles;
        logic       pst;
        logic [7:0] pd;
        logic       pl;
        cycles = 0; pst = 1'b0; pd = 8'h00; pl = 1'b0; timed_out = 1'b0;
        while (obs_q.size() < n) begin
            if (cycles >= budget) begin
                timed_out = 1'b1;
                break;
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (pst && (!m_valid_s || m_data_s !== pd || m_last_s !== pl)) stall_viol++;
            if (tail && s_ready_s && !frame_done_s) sready_viol++;
            if (frame_done_s) begin
                done_cnt++;
                tail = 1'b0;
            end
            if (m_valid_s && m_ready) obs_q.push_back('{d: m_data_s, l: m_last_s});
            pst = m_valid_s && !m_ready; pd = m_data_s; pl = m_last_s;
            @(posedge clk); #1;
            cycles++;
        end
        m_ready = 1'b1;
        @(negedge clk);
        if (frame_done_s) begin
            done_cnt++;
            tail = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1; rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #2;
            vectors++;
            if ({m_valid_s, m_data_s, m_last_s, frame_done_s, s_ready_s} !== 12'h000) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs sel=%0d: got v=%b d=%h l=%b fd=%b sr=%b, expected all 0",
                         s, m_valid_s, m_data_s, m_last_s, frame_done_s, s_ready_s);
            end
        end
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (s_ready_s !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", s_ready_s);
        end
    endtask

    task automatic test_basic_no_pad();
        bq_t   f, fcs_ref, seen;
        beat_t e, o;
        bit    to;
        do_reset();
        sel = 1'b0;
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        fcs_ref = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        fork
            drive_frame(f);
            collect(13, 1'b0, 500, to);
        join
        vectors++;
        if (to || drv_timeout) begin
            miscompares++;
            $display("[TB] FAIL basic_timeout: got timeout=%b/%b expected 0/0", to, drv_timeout);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            seen.push_back(o.d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL basic_byte%0d: got %h/%b expected %h/%b", k, o.d, o.l, e.d, e.l);
            end
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (seen.size() < 13 || seen[9 + k] !== fcs_ref[k]) begin
                miscompares++;
                $display("[TB] FAIL basic_fcs%0d: got %h expected %h", k,
                         (seen.size() > 9 + k) ? seen[9 + k] : 8'hxx, fcs_ref[k]);
            end
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("[TB] FAIL basic_frame_done: got %0d pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_single_byte_pad();
        bq_t         f;
        beat_t       e, o;
        bit          to;
        logic [31:0] rc;
        do_reset();
        sel = 1'b1;
        f = '{8'hAB};
        rc = 32'hFFFFFFFF;
        fork
            drive_frame(f);
            collect(64, 1'b0, 500, to);
        join
        vectors++;
        if (to || drv_timeout || exp_q.size() != 64) begin
            miscompares++;
            $display("[TB] FAIL pad_len: got timeout=%b/%b expected_len=%0d, expected 0/0 and 64", to, drv_timeout, exp_q.size());
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            rc = crc_step(rc, o.d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL pad_byte%0d: got %h/%b expected %h/%b", k, o.d, o.l, e.d, e.l);
            end
        end
        vectors++;
        if ({<<{rc}} !== CRC_RESIDUE) begin
            miscompares++;
            $display("[TB] FAIL pad_residue: got %h expected %h", {<<{rc}}, CRC_RESIDUE);
        end
    endtask

    task automatic test_exact_min();
        bq_t         f;
        beat_t       e, o;
        bit          to;
        logic [31:0] rc;
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 60; i++) f.push_back(8'(i));
        rc = 32'hFFFFFFFF;
        fork
            drive_frame(f);
            collect(64, 1'b0, 500, to);
        join
        vectors++;
        if (to || drv_timeout) begin
            miscompares++;
            $display("[TB] FAIL exact_timeout: got timeout=%b/%b expected 0/0", to, drv_timeout);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            rc = crc_step(rc, o.d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL exact_byte%0d: got %h/%b expected %h/%b", k, o.d, o.l, e.d, e.l);
            end
        end
        vectors++;
        if ({<<{rc}} !== CRC_RESIDUE) begin
            miscompares++;
            $display("[TB] FAIL exact_residue: got %h expected %h", {<<{rc}}, CRC_RESIDUE);
        end
    endtask

    task automatic test_random_stall();
        bq_t   f;
        beat_t e, o;
        bit    to;
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 100; i++) f.push_back(8'($urandom_range(0, 255)));
        fork
            drive_frame(f);
            collect(104, 1'b1, 3000, to);
        join
        vectors++;
        if (to || drv_timeout) begin
            miscompares++;
            $display("[TB] FAIL stall_timeout: got timeout=%b/%b expected 0/0", to, drv_timeout);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL stall_byte%0d: got %h/%b expected %h/%b", k, o.d, o.l, e.d, e.l);
            end
        end
        vectors++;
        if (stall_viol !== 0 || sready_viol !== 0 || obs_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_hold: got unstable=%0d ready_outside_pass=%0d extra=%0d expected 0/0/0",
                     stall_viol, sready_viol, obs_q.size());
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("[TB] FAIL stall_frame_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bq_t         f1, f2;
        beat_t       e, o;
        bit          to;
        int          frames;
        logic [31:0] rc;
        do_reset();
        sel = 1'b1;
        f1 = '{8'hDE, 8'hAD, 8'hBE};
        for (int i = 0; i < 70; i++) f2.push_back(8'(8'hA0 + i));
        rc = 32'hFFFFFFFF;
        frames = 0;
        fork
            begin
                drive_frame(f1);
                drive_frame(f2);
            end
            collect(138, 1'b0, 1000, to);
        join
        vectors++;
        if (to || drv_timeout) begin
            miscompares++;
            $display("[TB] FAIL b2b_timeout: got timeout=%b/%b expected 0/0", to, drv_timeout);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            rc = crc_step(rc, o.d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL b2b_byte%0d: got %h/%b expected %h/%b", k, o.d, o.l, e.d, e.l);
            end
            if (e.l) begin
                vectors++;
                if ({<<{rc}} !== CRC_RESIDUE) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_residue%0d: got %h expected %h", frames, {<<{rc}}, CRC_RESIDUE);
                end
                rc = 32'hFFFFFFFF;
                frames++;
            end
        end
        vectors++;
        if (done_cnt !== 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_frame_done: got %0d expected 2", done_cnt);
        end
    endtask

    task automatic test_reset_mid_pad();
        bq_t   f, fcs_ref, seen;
        beat_t e, o;
        bit    to;
        do_reset();
        sel = 1'b1;
        f = '{8'h55, 8'h66};
        drive_frame(f);
        repeat (5) @(posedge clk);
        #3;
        vectors++;
        if (m_valid_s !== 1'b1 || s_ready_s !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midpad_busy: got v=%b sr=%b expected 1/0", m_valid_s, s_ready_s);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({m_valid_s, m_data_s, m_last_s, frame_done_s, s_ready_s} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL midpad_async_reset: got v=%b d=%h l=%b fd=%b sr=%b expected all 0",
                     m_valid_s, m_data_s, m_last_s, frame_done_s, s_ready_s);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete(); obs_q.delete();
        tail = 1'b0; done_cnt = 0; drv_timeout = 1'b0;
        sel = 1'b0;
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        fcs_ref = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        fork
            drive_frame(f);
            collect(13, 1'b0, 500, to);
        join
        vectors++;
        if (to || drv_timeout) begin
            miscompares++;
            $display("[TB] FAIL after_reset_timeout: got timeout=%b/%b expected 0/0", to, drv_timeout);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            seen.push_back(o.d);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL after_reset_byte%0d: got %h/%b expected %h/%b", k, o.d, o.l, e.d, e.l);
            end
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (seen.size() < 13 || seen[9 + k] !== fcs_ref[k]) begin
                miscompares++;
                $display("[TB] FAIL after_reset_fcs%0d: got %h expected %h", k,
                         (seen.size() > 9 + k) ? seen[9 + k] : 8'hxx, fcs_ref[k]);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_basic_no_pad();
        test_single_byte_pad();
        test_exact_min();
        test_random_stall();
        test_back_to_back();
        test_reset_mid_pad();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
